rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Owns the register file's single write port (A3/WD3/WE3). Arbitrates between the pipeline writeback stage and a long-latency unit (mul/div, multi-cycle load) that returns results out of band.
- Keeps a per-register busy scoreboard so the decode stage can stall on RAW/WAW hazards against in-flight long-latency results.
- Sits between the WB stage, the long-latency unit, and the register file.

Parameters:
- XLEN, 32, data width of the register file.
- NREG, 32, number of architectural registers.
- AW, 5, register address width (clog2 NREG).
- STARVE_MAX, 4, consecutive cycles a valid long-latency result may lose arbitration before it is forced through.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- pipe_we  in  1  WB stage write request.
- pipe_rd  in  AW  WB stage destination.
- pipe_wd  in  XLEN  WB stage data.
- stall_wb  out  1  holds the WB stage; its write was not performed this cycle.
- lu_issue_valid  in  1  long-latency op issued, with a destination register.
- lu_issue_rd  in  AW  destination of the issued op.
- lu_issue_ready  out  1  issue accepted; low when lu_issue_rd is already busy.
- lu_res_valid  in  1  long-latency result available.
- lu_res_rd  in  AW  result destination.
- lu_res_wd  in  XLEN  result data.
- lu_res_ready  out  1  result consumed this cycle.
- id_rs1  in  AW  decode source 1 query.
- id_rs2  in  AW  decode source 2 query.
- id_rd  in  AW  decode destination query.
- busy_rs1  out  1  pending write on id_rs1.
- busy_rs2  out  1  pending write on id_rs2.
- busy_rd  out  1  pending write on id_rd.
- rf_we  out  1  to register file WE3.
- rf_a3  out  AW  to register file A3.
- rf_wd  out  XLEN  to register file WD3.

Behaviour:
- Reset (rst=0, async):
  - Scoreboard cleared and starve_cnt=0.
  - Outputs forced: rf_we=0, rf_a3=0, rf_wd=0, lu_res_ready=0, lu_issue_ready=0, stall_wb=0, all busy_*=0.
- Write-port outputs are combinational from the current-cycle grant. The register file captures them on negedge, so a write granted in cycle N is readable by decode in the second half of cycle N.
- Arbitration, evaluated every cycle:
  1. lu_res_valid=1 and starve_cnt==STARVE_MAX:
     - Long-latency result granted; lu_res_ready=1.
     - stall_wb=pipe_we.
     - starve_cnt cleared to 0.
  2. Else pipe_we=1:
     - Pipeline granted; lu_res_ready=0; stall_wb=0.
     - If lu_res_valid=1, starve_cnt increments; otherwise starve_cnt holds.
  3. Else lu_res_valid=1:
     - Long-latency result granted; lu_res_ready=1.
     - starve_cnt cleared to 0.
  4. Else: rf_we=0 and starve_cnt holds.
- starve_cnt width is clog2(STARVE_MAX+1). It saturates at STARVE_MAX and never wraps.
- x0: a grant whose destination is 0 drives rf_we=0, but the requester is still considered served (lu_res_ready=1 if the grant is a result). The x0 busy bit is never set, and busy_* is always 0 for address 0.
- Scoreboard:
  - A busy bit is set at posedge when lu_issue_valid & lu_issue_ready and lu_issue_rd≠0.
  - lu_issue_ready = ~busy[lu_issue_rd] | (lu_issue_rd==0).
  - A busy bit is cleared at posedge when lu_res_valid & lu_res_ready for that rd.
  - Same-cycle set and clear of the same rd: set wins.
  - Same-cycle bypass: busy_rsN = busy[rsN] & ~(lu_res_valid & lu_res_ready & lu_res_rd==rsN). busy_rd uses the same rule.
- Result for a non-busy rd: written normally, scoreboard unchanged. This is a protocol violation; the bench flags it, the RTL does not block it.
- Reset mid-operation: all pending busy bits are dropped. The long-latency unit shares rst, so no stale result follows.

Decomposition:
- Shared package rf_pkg: XLEN, NREG, AW, REG_ZERO (5'd0), and the STARVE_MAX default.
- One sub-module, rf_scoreboard:
  - NREG-bit busy vector.
  - Set and clear ports with set-wins priority.
  - Three combinational read ports with result-accept bypass.

Test Plan:
1. Reset: rst=0 while lu_res_valid=1 and pipe_we=1 -> rf_we=0, lu_res_ready=0, stall_wb=0, busy_*=0. Release rst -> pipe granted next cycle.
2. Issue then return: issue rd=7 -> busy_rs1=1 for id_rs1=7. Re-issue rd=7 -> lu_issue_ready=0. Result rd=7, wd=0xDEADBEEF with pipe_we=0 -> rf_we=1, rf_a3=7, lu_res_ready=1, busy_rs1=0 in that cycle, and the register file reads 0xDEADBEEF after negedge.
3. Starvation: pipe_we=1 continuously and lu_res_valid=1 from cycle 0 -> pipe wins cycles 0-3. In cycle 4: lu_res_ready=1, stall_wb=1, rf_a3=lu_res_rd. Cycle 5: pipe granted again.
4. Set/clear collision: result for rd=3 accepted while issuing rd=3 in the same cycle -> busy[3]=1 after the edge.
5. x0: issue rd=0 -> lu_issue_ready=1, busy unchanged. Result rd=0 -> lu_res_ready=1, rf_we=0. pipe_rd=0 with pipe_we=1 -> rf_we=0.
6. Async reset with busy[5]=1 and starve_cnt=2 -> asserting rst immediately drives busy_rd(5)=0 and outputs to their reset values, without waiting for a clk edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, defaults and the write-port grant encoding for the register-file
// writeback scheduler and its busy scoreboard.
package rf_pkg;

  localparam int XLEN           = 32;
  localparam int NREG           = 32;
  localparam int AW             = 5;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_LU
  } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector for in-flight long-latency results; set beats clear on
// the same register, and read ports see a result being accepted this cycle as done.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_rd,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_rd,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic [AW-1:0] i_rd,
  input  logic [AW-1:0] i_q_rd,
  output logic          o_busy_rs1,
  output logic          o_busy_rs2,
  output logic          o_busy_rd,
  output logic          o_busy_q
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_next = r_busy;
    if (i_clr_en) w_next[i_clr_rd] = 1'b0;
    if (i_set_en) w_next[i_set_rd] = 1'b1;
    w_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_next;
  end

  // Raw view for issue acceptance; bypassed views for decode hazard queries.
  assign o_busy_q   = r_busy[i_q_rd];
  assign o_busy_rs1 = r_busy[i_rs1] & ~(i_clr_en && (i_clr_rd == i_rs1));
  assign o_busy_rs2 = r_busy[i_rs2] & ~(i_clr_en && (i_clr_rd == i_rs2));
  assign o_busy_rd  = r_busy[i_rd]  & ~(i_clr_en && (i_clr_rd == i_rd));

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter between the WB stage and a long-latency unit,
// with a starvation bound for long-latency results and a busy scoreboard for decode.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [AW-1:0]   pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  output logic            stall_wb,
  input  logic            lu_issue_valid,
  input  logic [AW-1:0]   lu_issue_rd,
  output logic            lu_issue_ready,
  input  logic            lu_res_valid,
  input  logic [AW-1:0]   lu_res_rd,
  input  logic [XLEN-1:0] lu_res_wd,
  output logic            lu_res_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]   r_starve_cnt;
  grant_e          w_grant;
  logic            w_res_accept;
  logic            w_busy_issue;
  logic            w_set_en;
  logic [AW-1:0]   w_wr_rd;
  logic [XLEN-1:0] w_wr_wd;

  // Holding reset low suppresses every grant so the write port stays idle.
  always_comb begin
    w_grant = GRANT_NONE;
    if (lu_res_valid && (r_starve_cnt == CW'(STARVE_MAX))) w_grant = GRANT_LU;
    else if (pipe_we)                                      w_grant = GRANT_PIPE;
    else if (lu_res_valid)                                 w_grant = GRANT_LU;
    if (!rst) w_grant = GRANT_NONE;
  end

  assign w_res_accept = (w_grant == GRANT_LU);
  assign w_wr_rd      = w_res_accept ? lu_res_rd : pipe_rd;
  assign w_wr_wd      = w_res_accept ? lu_res_wd : pipe_wd;

  assign lu_res_ready = w_res_accept;
  assign stall_wb     = w_res_accept & pipe_we;
  assign rf_we        = (w_grant != GRANT_NONE) && (w_wr_rd != REG_ZERO);
  assign rf_a3        = (w_grant != GRANT_NONE) ? w_wr_rd : '0;
  assign rf_wd        = (w_grant != GRANT_NONE) ? w_wr_wd : '0;

  assign lu_issue_ready = rst & (~w_busy_issue | (lu_issue_rd == REG_ZERO));
  assign w_set_en       = lu_issue_valid & lu_issue_ready & (lu_issue_rd != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else begin
      case (w_grant)
        GRANT_LU:   r_starve_cnt <= '0;
        GRANT_PIPE: if (lu_res_valid && (r_starve_cnt < CW'(STARVE_MAX)))
                      r_starve_cnt <= r_starve_cnt + CW'(1);
        default:    r_starve_cnt <= r_starve_cnt;
      endcase
    end
  end

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_set_en),
    .i_set_rd   (lu_issue_rd),
    .i_clr_en   (w_res_accept),
    .i_clr_rd   (lu_res_rd),
    .i_rs1      (id_rs1),
    .i_rs2      (id_rs2),
    .i_rd       (id_rd),
    .i_q_rd     (lu_issue_rd),
    .o_busy_rs1 (busy_rs1),
    .o_busy_rs2 (busy_rs2),
    .o_busy_rd  (busy_rd),
    .o_busy_q   (w_busy_issue)
  );

endmodule
